prbs_rx_par: RTL

Parallel, run-time-configurable PRBS checker. It is the multi-bit successor of the single-bit PRBS receiver. It accepts DATA_W bits per valid cycle, self-synchronises to one of six standard polynomials, and counts bits and bit errors only while locked. It detects loss of lock and re-enters search automatically. It sits after the deserialiser in BER-test datapaths and drives status registers.

---
 rtl/prbs_rx_par_if.sv | 28 ++
 rtl/prbs_rx_par.sv | 181 ++++++++++++++++++
 2 files changed

// File: rtl/prbs_rx_par_if.sv
// Bus bundle for the parallel PRBS checker: configuration, input word stream and status outputs.
interface prbs_rx_par_if #(
    parameter int DATA_W        = 8,
    parameter int BIT_CNT_WIDTH = 32,
    parameter int ERR_CNT_WIDTH = 16
);
    logic [2:0]               prbs_sel;
    logic                     inv;
    logic                     clr;
    logic                     din_vld;
    logic [DATA_W-1:0]        din;
    logic [BIT_CNT_WIDTH-1:0] bit_cnt;
    logic [ERR_CNT_WIDTH-1:0] err_cnt;
    logic                     err_sat;
    logic                     locked;
    logic                     lock_lost;
    logic                     err_word;

    modport master (
        output prbs_sel, inv, clr, din_vld, din,
        input  bit_cnt, err_cnt, err_sat, locked, lock_lost, err_word
    );

    modport slave (
        input  prbs_sel, inv, clr, din_vld, din,
        output bit_cnt, err_cnt, err_sat, locked, lock_lost, err_word
    );
endinterface

// File: rtl/prbs_rx_par.sv
// Parallel self-synchronising PRBS checker with lock/loss-of-lock tracking and saturating BER counters.
//   state  | meaning
//   SEARCH | history loaded from received bits, counting consecutive clean words
//   LOCK   | history free-runs on generated bits, bits and errors are counted
module prbs_rx_par #(
    parameter int DATA_W        = 8,
    parameter int BIT_CNT_WIDTH = 32,
    parameter int ERR_CNT_WIDTH = 16,
    parameter int SYNC_LEN      = 64,
    parameter int LOS_WIN       = 256,
    parameter int LOS_THR       = 16
) (
    input logic          clk,
    input logic          rst,
    prbs_rx_par_if.slave bus
);
    localparam int SW = $clog2(SYNC_LEN + 1);
    localparam int WW = $clog2(LOS_WIN + 1);
    localparam int BDW = $clog2(LOS_THR + 1);
    localparam int BW = BIT_CNT_WIDTH + 1;
    localparam int EW = ((ERR_CNT_WIDTH > 7) ? ERR_CNT_WIDTH : 7) + 1;
    localparam logic [ERR_CNT_WIDTH-1:0] ERR_MAX = '1;

    typedef enum logic [0:0] {SEARCH, LOCK} state_t;

    state_t                   state, state_n;
    logic                     s1_vld;
    logic [DATA_W-1:0]        s1_data;
    logic [2:0]               s1_sel, sel_q;
    logic [30:0]              hist, hist_n, hist_gen, h;
    logic [SW-1:0]            sync_cnt, sync_n;
    logic [WW-1:0]            win_cnt, win_n;
    logic [BDW-1:0]           bad_cnt, bad_n;
    logic [BIT_CNT_WIDTH-1:0] bit_cnt, bit_n, bit_inc;
    logic [ERR_CNT_WIDTH-1:0] err_cnt, err_n, err_inc;
    logic                     err_sat, sat_n, lock_lost, lost_n, err_word, errw_n;
    logic [4:0]               tap_a, tap_b;
    logic [DATA_W-1:0]        err_vec;
    logic                     eb, word_err, refused, sel_chg;
    logic [6:0]               pop;
    logic [BW-1:0]            bit_sum;
    logic [EW-1:0]            err_sum;

    always_comb begin
        tap_a = 5'd7;
        tap_b = 5'd6;
        case (s1_sel)
            3'd1:    begin tap_a = 5'd9;  tap_b = 5'd5;  end
            3'd2:    begin tap_a = 5'd11; tap_b = 5'd9;  end
            3'd3:    begin tap_a = 5'd15; tap_b = 5'd14; end
            3'd4:    begin tap_a = 5'd23; tap_b = 5'd18; end
            3'd5:    begin tap_a = 5'd31; tap_b = 5'd28; end
            default: begin tap_a = 5'd7;  tap_b = 5'd6;  end
        endcase
    end

    // hist[0] is the most recent bit; earlier bits of a word feed later bits of the same word
    always_comb begin
        h       = hist;
        eb      = 1'b0;
        err_vec = '0;
        pop     = '0;
        for (int k = DATA_W - 1; k >= 0; k--) begin
            eb         = h[tap_a - 5'd1] ^ h[tap_b - 5'd1];
            err_vec[k] = eb ^ s1_data[k];
            pop        = pop + 7'(err_vec[k]);
            h          = {h[29:0], (state == LOCK) ? eb : s1_data[k]};
        end
        hist_gen = h;
    end

    assign word_err = |err_vec;
    assign refused  = s1_sel[2] & s1_sel[1];
    assign sel_chg  = (s1_sel != sel_q);
    assign bit_sum  = BW'(bit_cnt) + BW'(DATA_W);
    assign bit_inc  = bit_sum[BIT_CNT_WIDTH] ? '1 : bit_sum[BIT_CNT_WIDTH-1:0];
    assign err_sum  = EW'(err_cnt) + EW'(pop);
    assign err_inc  = (err_sum > EW'(ERR_MAX)) ? ERR_MAX : err_sum[ERR_CNT_WIDTH-1:0];

    always_comb begin
        state_n = state;
        hist_n  = hist;
        sync_n  = sync_cnt;
        win_n   = win_cnt;
        bad_n   = bad_cnt;
        bit_n   = bit_cnt;
        err_n   = err_cnt;
        sat_n   = err_sat;
        lost_n  = lock_lost;
        errw_n  = 1'b0;
        if (s1_vld) hist_n = hist_gen;
        if (sel_chg || refused) begin
            state_n = SEARCH;
            sync_n  = '0;
            win_n   = '0;
            bad_n   = '0;
        end else if (s1_vld) begin
            case (state)
                SEARCH: begin
                    if (word_err) begin
                        sync_n = '0;
                    end else if (sync_cnt == SW'(SYNC_LEN - 1)) begin
                        state_n = LOCK;
                        sync_n  = SW'(SYNC_LEN);
                        win_n   = '0;
                        bad_n   = '0;
                    end else begin
                        sync_n = sync_cnt + SW'(1);
                    end
                end
                LOCK: begin
                    bit_n  = bit_inc;
                    err_n  = err_inc;
                    errw_n = word_err;
                    sat_n  = err_sat | (&bit_inc) | (&err_inc);
                    if (word_err && (bad_cnt == BDW'(LOS_THR - 1))) begin
                        state_n = SEARCH;
                        lost_n  = 1'b1;
                        sync_n  = '0;
                        win_n   = '0;
                        bad_n   = '0;
                    end else if (win_cnt == WW'(LOS_WIN - 1)) begin
                        win_n = '0;
                        bad_n = '0;
                    end else begin
                        win_n = win_cnt + WW'(1);
                        bad_n = bad_cnt + BDW'(word_err);
                    end
                end
                default: state_n = SEARCH;
            endcase
        end
        if (bus.clr) begin
            bit_n  = '0;
            err_n  = '0;
            sat_n  = 1'b0;
            lost_n = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            s1_vld    <= 1'b0;
            s1_data   <= '0;
            s1_sel    <= '0;
            sel_q     <= '0;
            state     <= SEARCH;
            hist      <= '0;
            sync_cnt  <= '0;
            win_cnt   <= '0;
            bad_cnt   <= '0;
            bit_cnt   <= '0;
            err_cnt   <= '0;
            err_sat   <= 1'b0;
            lock_lost <= 1'b0;
            err_word  <= 1'b0;
        end else begin
            s1_vld    <= bus.din_vld;
            s1_data   <= bus.din ^ {DATA_W{bus.inv}};
            s1_sel    <= bus.prbs_sel;
            sel_q     <= s1_sel;
            state     <= state_n;
            hist      <= hist_n;
            sync_cnt  <= sync_n;
            win_cnt   <= win_n;
            bad_cnt   <= bad_n;
            bit_cnt   <= bit_n;
            err_cnt   <= err_n;
            err_sat   <= sat_n;
            lock_lost <= lost_n;
            err_word  <= errw_n;
        end
    end

    assign bus.bit_cnt   = bit_cnt;
    assign bus.err_cnt   = err_cnt;
    assign bus.err_sat   = err_sat;
    assign bus.locked    = (state == LOCK);
    assign bus.lock_lost = lock_lost;
    assign bus.err_word  = err_word;
endmodule
